regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

- Shares the single write port of `RegisterFile` between two sources:
  - the in-order pipeline writeback stage (WB);
  - the multi-cycle M-extension mul/div unit (MDU).
- Keeps MDU results in a small queue until a write slot is free, and forces a WB hold if an MDU result waits too long.
- Keeps a per-register pending scoreboard, so decode can detect RAW hazards on MDU destinations.
- Sits between WB/MDU and the register file's `WRITEENABLE`/`WRITEADDRESS`/`WRITEDATA` inputs.

## Interface

Parameters:

- `DEPTH`, default 2: MDU result queue entries; a power of two, at least 2.
- `STARVE_LIMIT`, default 4: cycles a queued MDU head may be denied before it is forced through; range 1..15.

Ports:

- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: reset, synchronous, active-low.
- `WB_EN` input 1: pipeline writeback valid.
- `WB_RD` input 5: pipeline destination register.
- `WB_DATA` input 32: pipeline write data.
- `WB_HOLD` output 1: combinational; the WB write was not taken this cycle, and the pipeline must hold WB/MEM/EX.
- `MD_VALID` input 1: MDU result valid.
- `MD_READY` output 1: the queue can accept a result.
- `MD_RD` input 5: MDU destination register.
- `MD_DATA` input 32: MDU result.
- `ISSUE_EN` input 1: an MDU op is issued this cycle.
- `ISSUE_RD` input 5: destination register of the issued MDU op.
- `RS1` input 5: decode source 1.
- `RS2` input 5: decode source 2.
- `RS1_BUSY` output 1: combinational; `RS1` has an outstanding MDU write.
- `RS2_BUSY` output 1: combinational; `RS2` has an outstanding MDU write.
- `RF_WE` output 1: registered; drives `WRITEENABLE`.
- `RF_WADDR` output 5: registered; drives `WRITEADDRESS`.
- `RF_WDATA` output 32: registered; drives `WRITEDATA`.

## Operation

- **Reset.** When `RESET`=0 at a rising edge, the following are cleared:
  - the queue (empty) and the starve counter (0);
  - all 32 pending bits;
  - `RF_WE`, `RF_WADDR` and `RF_WDATA` (all 0).
- **Outputs during reset.** While `RESET`=0: `MD_READY`=0, `WB_HOLD`=0, `RSx_BUSY`=0.
- **Reset mid-operation.** Queued results and pending bits are discarded; there is no partial write.
- **Definitions.**
  - `wb_req` = `WB_EN` && `WB_RD`≠0.
  - `q_req` = queue non-empty.
- **Grant to the queue head** when `q_req` && (!`wb_req` || starve ≥ `STARVE_LIMIT`). Otherwise `wb_req` is granted.
- **WB hold.** `WB_HOLD` = `wb_req` && queue granted.
- **Queue handshake.**
  - `MD_READY` = count < `DEPTH`, taken from the registered count, so a pop in the same cycle does not raise `READY`.
  - A transfer happens on `MD_VALID`&&`MD_READY` at the edge.
  - A result with `MD_RD`=0 is accepted and dropped, with no enqueue.
- **Same-cycle push and pop.** Both are legal; count is unchanged and order is FIFO. Pointers wrap modulo `DEPTH`.
- **Starve counter.**
  - Increments when `q_req` and the head is not granted.
  - Resets to 0 on any pop and whenever the queue is empty.
  - Saturates at `STARVE_LIMIT`.
- **Scoreboard.**
  - `ISSUE_EN` with `ISSUE_RD`≠0 sets `pending[ISSUE_RD]`.
  - A pop of a queue head clears `pending[head.rd]`.
  - If a set and a clear hit the same register in one cycle, the set wins.
  - `RSx_BUSY` = `pending[RSx]`; x0 is never busy.
- **Pipeline obligations.** These are not checked in RTL; the bench asserts them.
  - No `ISSUE_EN` to a register that is already pending (WAW).
  - No WB write to a pending register.

## Timing

- **Grant to register-file write.** A grant in cycle N drives `RF_WE`/`RF_WADDR`/`RF_WDATA` during cycle N+1, and `RegisterFile` commits at the end of N+1.
- **No grant.** With no grant, `RF_WE`=0 and `RF_WADDR`/`RF_WDATA` hold their previous values.
- **MDU latency.** MDU handshake at edge E → earliest grant in the cycle after E → `RF_WE` high one cycle later.
- **WB latency.** An un-held WB write appears on `RF_*` one cycle after `WB_EN`.
- **WB hold.**
  - `WB_HOLD` is valid combinationally in the same cycle.
  - The held WB request is re-presented unchanged.
  - The starve counter reset guarantees it wins within 1 cycle unless the queue still holds another starved entry.
- **Pending bit clear.** A pending bit clears at the pop edge, one cycle before the register-file commit. Decode must also cover that cycle via the existing forwarding on `RF_WADDR`.

## Test plan

- **Reset.** Hold `RESET`=0 for 2 edges, release → `RF_WE`=0, `RF_WADDR`=0, `MD_READY`=1, `RS1_BUSY`=0 for all `RS1`.
- **Idle-slot drain.** `ISSUE_EN` with rd=5, then `MD_VALID` with rd=5 and data 0xDEADBEEF, with `WB_EN`=0 → `RS1`=5 busy until the pop edge; `RF_WE`=1, `RF_WADDR`=5, `RF_WDATA`=0xDEADBEEF two cycles after the handshake.
- **Starvation.** `STARVE_LIMIT`=4, continuous WB writes to x1, one queued MDU result to x7 → WB is granted for 4 cycles, then `WB_HOLD`=1 for exactly 1 cycle; x7 is written, then the held x1 write follows.
- **Full queue.** `DEPTH`=2, `WB_EN` continuously active, `STARVE_LIMIT`=15, push 2 results → `MD_READY`=0. Further `MD_VALID` is ignored until the first forced pop; FIFO order is preserved, with no loss or duplication.
- **x0 handling.** `MD_RD`=0 and `ISSUE_RD`=0 → accepted, no enqueue, no pending bit, `RF_WE` stays 0.
- **Mid-operation reset.** Reset with 2 queued entries and 3 pending bits → queue empty, all busy bits 0, and no `RF_WE` pulse after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between the in-order
//   writeback stage (WB) and the multi-cycle mul/div unit (MDU). MDU results
//   wait in a small FIFO until the port is free. A WB hold is forced when the
//   queue head has been denied STARVE_LIMIT times. A per-register pending
//   scoreboard lets decode see RAW hazards on outstanding MDU destinations.
// Ports
//   CLK, RESET                    clock, synchronous active-low reset
//   WB_EN/WB_RD/WB_DATA, WB_HOLD  writeback request, combinational hold back
//   MD_VALID/MD_RD/MD_DATA        MDU result, accepted when MD_READY
//   ISSUE_EN/ISSUE_RD             MDU issue, sets the pending bit
//   RS1/RS2 -> RS1_BUSY/RS2_BUSY  decode hazard lookup (combinational)
//   RF_WE/RF_WADDR/RF_WDATA       registered register-file write port
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WB_EN,
  input  logic [4:0]  WB_RD,
  input  logic [31:0] WB_DATA,
  output logic        WB_HOLD,
  input  logic        MD_VALID,
  output logic        MD_READY,
  input  logic [4:0]  MD_RD,
  input  logic [31:0] MD_DATA,
  input  logic        ISSUE_EN,
  input  logic [4:0]  ISSUE_RD,
  input  logic [4:0]  RS1,
  input  logic [4:0]  RS2,
  output logic        RS1_BUSY,
  output logic        RS2_BUSY,
  output logic        RF_WE,
  output logic [4:0]  RF_WADDR,
  output logic [31:0] RF_WDATA
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  logic [4:0]    rd_q   [DEPTH];
  logic [4:0]    rd_d   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic [31:0]   pend_q, pend_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic wb_req, q_req, q_gnt, wb_gnt, push;

  always_comb begin
    wb_req   = WB_EN && (WB_RD != 5'd0);
    q_req    = (cnt_q != '0);
    // Queue head wins on an idle slot or once it has starved long enough.
    q_gnt    = RESET && q_req && (!wb_req || (starve_q >= STARVE_MAX));
    wb_gnt   = RESET && wb_req && !q_gnt;
    WB_HOLD  = wb_req && q_gnt;
    // Registered count only: a same-cycle pop does not open a slot.
    MD_READY = RESET && (cnt_q < DEPTH_C);
    // Results to x0 complete the handshake but are never queued.
    push     = MD_VALID && MD_READY && (MD_RD != 5'd0);
    RS1_BUSY = RESET && (RS1 != 5'd0) && pend_q[RS1];
    RS2_BUSY = RESET && (RS2 != 5'd0) && pend_q[RS2];

    rd_d   = rd_q;
    data_d = data_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      rd_d[wptr_q]   = MD_RD;
      data_d[wptr_q] = MD_DATA;
      wptr_d         = wptr_q + AW'(1);
    end
    if (q_gnt) rptr_d = rptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(q_gnt);

    if (!q_req || q_gnt)          starve_d = 4'd0;
    else if (starve_q < STARVE_MAX) starve_d = starve_q + 4'd1;
    else                          starve_d = starve_q;

    // Clear before set so an issue to the register being popped wins.
    pend_d = pend_q;
    if (q_gnt) pend_d[rd_q[rptr_q]] = 1'b0;
    if (ISSUE_EN && (ISSUE_RD != 5'd0)) pend_d[ISSUE_RD] = 1'b1;

    rf_we_d    = q_gnt || wb_gnt;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (q_gnt) begin
      rf_waddr_d = rd_q[rptr_q];
      rf_wdata_d = data_q[rptr_q];
    end else if (wb_gnt) begin
      rf_waddr_d = WB_RD;
      rf_wdata_d = WB_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      pend_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rd_q       <= rd_d;
      data_q     <= data_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      pend_q     <= pend_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign RF_WE    = rf_we_q;
  assign RF_WADDR = rf_waddr_q;
  assign RF_WDATA = rf_wdata_q;
endmodule
